tlc_sequencer: RTL and testbench

Sequencer that drives the traffic light controller's `enable`, `Sa` and `Sb` inputs. It generates the one-cycle step pulse from a clock prescaler and debounces the raw road sensors into qualified levels. It supports operator hold and an emergency pre-emption that steers road A to green. It sits between board I/O and the light FSM, and observes the FSM's `G_a`/`G_b` outputs as status.

---
 rtl/tlc_sequencer.sv | 155 +++++++++++++++
 tb/tb_tlc_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tlc_sequencer.sv
// Step-pulse prescaler, sensor debounce and RUN/PAUSE/PREEMPT mode control for the light FSM.
// Optional emergency pre-emption is compiled in with `define TLC_PREEMPT_EN.
module tlc_sequencer #(
  parameter int unsigned TICK_DIV   = 4,
  parameter int unsigned DEB_CYCLES = 3,
  parameter int unsigned WAIT_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sa_raw,
  input  logic              sb_raw,
  input  logic              hold,
  input  logic              preempt_a,
  input  logic              G_a,
  input  logic              G_b,
  output logic              enable,
  output logic              Sa,
  output logic              Sb,
  output logic              paused,
  output logic              preempt_active,
  output logic [WAIT_W-1:0] b_wait
);

  localparam int unsigned PCNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(TICK_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEB_CYCLES - 1);

`ifdef TLC_PREEMPT_EN
  typedef enum logic [1:0] {
    MODE_RUN     = 2'd0,
    MODE_PAUSE   = 2'd1,
    MODE_PREEMPT = 2'd2
  } mode_e;
`else
  typedef enum logic [1:0] {
    MODE_RUN   = 2'd0,
    MODE_PAUSE = 2'd1
  } mode_e;
`endif

  mode_e             mode;
  mode_e             mode_nxt;
  logic [PCNT_W-1:0] pcnt;
  logic              tick_c;
  logic              qa;
  logic              qb;
  logic [DEB_W-1:0]  cnt_a;
  logic [DEB_W-1:0]  cnt_b;
  logic              unused_status;

  // Mode request priority: preempt_a over hold over free-running.
  always_comb begin
    mode_nxt = MODE_RUN;
    if (hold) begin
      mode_nxt = MODE_PAUSE;
    end
`ifdef TLC_PREEMPT_EN
    if (preempt_a) begin
      mode_nxt = MODE_PREEMPT;
    end
`endif
  end

  // A wrap is withheld while paused or entering pause, so pcnt parks at its last value.
  always_comb begin
    tick_c = (pcnt == PCNT_MAX) && (mode != MODE_PAUSE) && (mode_nxt != MODE_PAUSE);
  end

`ifdef TLC_PREEMPT_EN
  assign unused_status = G_a;
`else
  assign unused_status = G_a ^ preempt_a;
  assign preempt_active = 1'b0;
`endif

  // Mode register, prescaler and registered outputs to the light FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode    <= MODE_RUN;
      pcnt    <= '0;
      enable  <= 1'b0;
      Sa      <= 1'b0;
      Sb      <= 1'b0;
      paused  <= 1'b0;
`ifdef TLC_PREEMPT_EN
      preempt_active <= 1'b0;
`endif
    end else begin
      mode   <= mode_nxt;
      enable <= tick_c;
      paused <= (mode_nxt == MODE_PAUSE);
`ifdef TLC_PREEMPT_EN
      preempt_active <= (mode_nxt == MODE_PREEMPT);
      if (mode_nxt == MODE_PREEMPT) begin
        Sa <= 1'b1;
        Sb <= 1'b0;
      end else begin
        Sa <= qa;
        Sb <= qb;
      end
`else
      Sa <= qa;
      Sb <= qb;
`endif
      if (tick_c) begin
        pcnt <= '0;
      end else if ((mode != MODE_PAUSE) && (pcnt != PCNT_MAX)) begin
        pcnt <= pcnt + PCNT_W'(1);
      end
    end
  end

  // Road A debounce: qualified level flips after DEB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      qa    <= 1'b0;
      cnt_a <= '0;
    end else if (sa_raw == qa) begin
      cnt_a <= '0;
    end else if (cnt_a == DEB_LAST) begin
      qa    <= ~qa;
      cnt_a <= '0;
    end else begin
      cnt_a <= cnt_a + DEB_W'(1);
    end
  end

  // Road B debounce, same scheme as road A.
  always_ff @(posedge clk) begin
    if (reset) begin
      qb    <= 1'b0;
      cnt_b <= '0;
    end else if (sb_raw == qb) begin
      cnt_b <= '0;
    end else if (cnt_b == DEB_LAST) begin
      qb    <= ~qb;
      cnt_b <= '0;
    end else begin
      cnt_b <= cnt_b + DEB_W'(1);
    end
  end

  // Road B starvation counter; green B clears it ahead of any increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      b_wait <= '0;
    end else if (G_b) begin
      b_wait <= '0;
    end else if (tick_c && qb && (b_wait != '1)) begin
      b_wait <= b_wait + WAIT_W'(1);
    end
  end

endmodule

// File: tb/tb_tlc_sequencer.sv
// Directed bench for tlc_sequencer: expectations are queued before each clock edge and checked after it.
module tb_tlc_sequencer;

  localparam int unsigned TICK_DIV   = 4;
  localparam int unsigned DEB_CYCLES = 3;
  localparam int unsigned WAIT_W     = 8;

  localparam int ID_EN = 0;
  localparam int ID_SA = 1;
  localparam int ID_SB = 2;
  localparam int ID_PA = 3;
  localparam int ID_PR = 4;
  localparam int ID_BW = 5;

  typedef struct {
    string       tag;
    int          id;
    logic [31:0] val;
  } exp_t;

  logic              clk;
  logic              reset;
  logic              sa_raw;
  logic              sb_raw;
  logic              hold;
  logic              preempt_a;
  logic              G_a;
  logic              G_b;
  logic              enable;
  logic              Sa;
  logic              Sb;
  logic              paused;
  logic              preempt_active;
  logic [WAIT_W-1:0] b_wait;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   e      = 0;
  int   off    = 0;

  tlc_sequencer #(
    .TICK_DIV  (TICK_DIV),
    .DEB_CYCLES(DEB_CYCLES),
    .WAIT_W    (WAIT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .sa_raw        (sa_raw),
    .sb_raw        (sb_raw),
    .hold          (hold),
    .preempt_a     (preempt_a),
    .G_a           (G_a),
    .G_b           (G_b),
    .enable        (enable),
    .Sa            (Sa),
    .Sb            (Sb),
    .paused        (paused),
    .preempt_active(preempt_active),
    .b_wait        (b_wait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] obs(int id);
    case (id)
      ID_EN:   return 32'(enable);
      ID_SA:   return 32'(Sa);
      ID_SB:   return 32'(Sb);
      ID_PA:   return 32'(paused);
      ID_PR:   return 32'(preempt_active);
      default: return 32'(b_wait);
    endcase
  endfunction

  task automatic check(string tag, logic [31:0] o, logic [31:0] ex);
    checks++;
    assert (o === ex) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, ex);
    end
  endtask

  task automatic want(string tag, int id, logic [31:0] v);
    exp_t x;
    x.tag = tag;
    x.id  = id;
    x.val = v;
    sb_q.push_back(x);
  endtask

  // Advance one clock edge and retire everything queued for it.
  task automatic cyc();
    exp_t x;
    @(posedge clk);
    #1;
    e++;
    while (sb_q.size() > 0) begin
      x = sb_q.pop_front();
      check(x.tag, obs(x.id), x.val);
    end
  endtask

  // Edge where the prescaler is free-running; pulse expected every TICK_DIV edges from phase off.
  task automatic run_edge();
    want("enable", ID_EN, 32'(((e + 1 - off) % int'(TICK_DIV)) == 0));
    cyc();
  endtask

  task automatic quiet_edge();
    want("enable_quiet", ID_EN, 32'(0));
    cyc();
  endtask

  initial begin
    reset     = 1'b1;
    sa_raw    = 1'b0;
    sb_raw    = 1'b0;
    hold      = 1'b0;
    preempt_a = 1'b0;
    G_a       = 1'b0;
    G_b       = 1'b0;

    cyc();
    cyc();
    want("rst_enable", ID_EN, 32'(0));
    want("rst_Sa", ID_SA, 32'(0));
    want("rst_Sb", ID_SB, 32'(0));
    want("rst_paused", ID_PA, 32'(0));
    want("rst_preempt", ID_PR, 32'(0));
    want("rst_b_wait", ID_BW, 32'(0));
    cyc();

    // Free-running pulses after release: edges 4, 8, 12.
    reset = 1'b0;
    e = 0;
    off = 0;
    for (int i = 0; i < 12; i++) run_edge();
    want("idle_Sa", ID_SA, 32'(0));
    want("idle_Sb", ID_SB, 32'(0));
    want("idle_b_wait", ID_BW, 32'(0));
    run_edge();

    // Two-cycle glitch on road B must not qualify.
    sb_raw = 1'b1;
    for (int i = 0; i < 2; i++) begin want("glitch_Sb", ID_SB, 32'(0)); run_edge(); end
    sb_raw = 1'b0;
    want("glitch_Sb", ID_SB, 32'(0));
    run_edge();

    // Stable rise: Sb follows one edge after the third sampling edge.
    sb_raw = 1'b1;
    for (int i = 0; i < 3; i++) begin want("rise_Sb_low", ID_SB, 32'(0)); run_edge(); end
    want("rise_Sb_high", ID_SB, 32'(1));
    run_edge();
    sb_raw = 1'b0;
    for (int i = 0; i < 3; i++) begin want("fall_Sb_high", ID_SB, 32'(1)); run_edge(); end
    want("fall_Sb_low", ID_SB, 32'(0));
    want("b_wait_one", ID_BW, 32'(1));
    run_edge();

    // Hold arriving with the prescaler at its last count.
    for (int i = 0; i < 3; i++) run_edge();
    hold = 1'b1;
    for (int i = 0; i < 10; i++) begin want("hold_paused", ID_PA, 32'(1)); quiet_edge(); end
    hold = 1'b0;
    want("resume_paused", ID_PA, 32'(0));
    quiet_edge();
    off = 3;
    for (int i = 0; i < 9; i++) run_edge();

    // Road B waiting: counts on ticks, saturates, then clears on green B.
    sb_raw = 1'b1;
    for (int i = 0; i < 11; i++) run_edge();
    want("b_wait_count", ID_BW, 32'(4));
    run_edge();
    for (int i = 0; i < 1240; i++) run_edge();
    want("b_wait_sat", ID_BW, 32'(255));
    run_edge();
    G_b = 1'b1;
    want("b_wait_clear", ID_BW, 32'(0));
    want("wait_Sb", ID_SB, 32'(1));
    run_edge();
    G_b = 1'b0;

    // Emergency request together with operator hold.
    sa_raw    = 1'b0;
    hold      = 1'b1;
    preempt_a = 1'b1;
`ifdef TLC_PREEMPT_EN
    for (int i = 0; i < 8; i++) begin
      want("pre_active", ID_PR, 32'(1));
      want("pre_paused", ID_PA, 32'(0));
      want("pre_Sa", ID_SA, 32'(1));
      want("pre_Sb", ID_SB, 32'(0));
      run_edge();
    end
    preempt_a = 1'b0;
    want("post_pre_active", ID_PR, 32'(0));
    want("post_pre_paused", ID_PA, 32'(1));
    want("post_pre_Sa", ID_SA, 32'(0));
    want("post_pre_Sb", ID_SB, 32'(1));
    quiet_edge();
    for (int i = 0; i < 3; i++) quiet_edge();
`else
    for (int i = 0; i < 8; i++) begin
      want("nopre_active", ID_PR, 32'(0));
      want("nopre_paused", ID_PA, 32'(1));
      want("nopre_Sa", ID_SA, 32'(0));
      want("nopre_Sb", ID_SB, 32'(1));
      quiet_edge();
    end
`endif

    // Reset in the middle of a pause.
    reset = 1'b1;
    want("mid_rst_enable", ID_EN, 32'(0));
    want("mid_rst_Sa", ID_SA, 32'(0));
    want("mid_rst_Sb", ID_SB, 32'(0));
    want("mid_rst_paused", ID_PA, 32'(0));
    want("mid_rst_preempt", ID_PR, 32'(0));
    want("mid_rst_b_wait", ID_BW, 32'(0));
    cyc();

    // Restart from reset with road A demand.
    reset     = 1'b0;
    hold      = 1'b0;
    preempt_a = 1'b0;
    sb_raw    = 1'b0;
    sa_raw    = 1'b1;
    e   = 0;
    off = 0;
    for (int i = 0; i < 3; i++) begin want("restart_Sa_low", ID_SA, 32'(0)); run_edge(); end
    want("restart_Sa_high", ID_SA, 32'(1));
    run_edge();
    for (int i = 0; i < 3; i++) run_edge();
    want("restart_paused", ID_PA, 32'(0));
    want("restart_Sb", ID_SB, 32'(0));
    run_edge();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
